// File: rtl/uart_pkg.sv
// Shared UART constants and transmitter state encoding.
// The baud generator elsewhere in the codebase uses the same defaults.
package uart_pkg;

    localparam int DATA_BITS    = 8;
    localparam int STOP_BITS    = 1;
    localparam int DEF_CLK_FREQ = 100_000_000;
    localparam int DEF_BAUD     = 9600;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t START = 2'd1;
    localparam state_t DATA  = 2'd2;
    localparam state_t STOP  = 2'd3;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter producing a one-cycle tick every BIT_CYCLES clocks.
// Holding clear restarts the period so the first bit after a grant is full length.
module uart_baud_tick #(
    parameter int BIT_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding one 8N1 UART transmitter shared by NUM_REQ byte producers.
// A grant captures the requester's byte; the frame then runs to completion before re-arbitration.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] active_id,
    output logic                       busy,
    output logic                       tx
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int ID_W       = $clog2(NUM_REQ);
    localparam int IDX_W      = $clog2(DATA_BITS);

    // First asserted request at or above ptr, wrapping; returns {found, index}.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [ID_W-1:0]    ptr);
        logic            found;
        logic [ID_W-1:0] idx;
        int              j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!found && r[j]) begin
                found = 1'b1;
                idx   = ID_W'(j);
            end
        end
        return {found, idx};
    endfunction

    state_t            state_q,     state_d;
    logic [ID_W-1:0]   ptr_q,       ptr_d;
    logic [ID_W-1:0]   active_id_q, active_id_d;
    logic [7:0]        shift_q,     shift_d;
    logic [IDX_W-1:0]  bit_idx_q,   bit_idx_d;
    logic              tx_q,        tx_d;
    logic              busy_q,      busy_d;

    logic [ID_W:0]     pick;
    logic [ID_W-1:0]   sel;
    logic              grant_en;
    logic              tick;

    assign pick     = rr_pick(req, ptr_q);
    assign sel      = pick[ID_W-1:0];
    // Gated by rst so no grant can leak out while the block is held in reset.
    assign grant_en = (state_q == IDLE) && pick[ID_W] && !rst;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign grant[gi] = grant_en && (sel == ID_W'(gi));
        end
    endgenerate

    uart_baud_tick #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q == IDLE),
        .tick (tick)
    );

    // tx_d is the value for the cycle after the edge, so tx is a clean register output.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        active_id_d = active_id_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (grant_en) begin
                    shift_d     = req_data[8*sel +: 8];
                    active_id_d = sel;
                    busy_d      = 1'b1;
                    ptr_d       = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
                    bit_idx_d   = '0;
                    tx_d        = 1'b0;
                    state_d     = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d   = STOP;
                        bit_idx_d = '0;
                        tx_d      = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shift_q[bit_idx_q + 1'b1];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_idx_q == IDX_W'(STOP_BITS - 1)) begin
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                    tx_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            active_id_q <= '0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            active_id_q <= active_id_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q | grant_en;
    assign active_id = active_id_q;

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART serial transmit line among NUM_REQ byte requesters using round-robin arbitration.
- Sequences each granted byte as an 8N1 frame: start bit, 8 data bits LSB first, 1 stop bit.
- Bit timing comes from an internal single-cycle baud tick, at 100 MHz / 9600 baud by default.
- Sits between on-chip byte producers (status, debug, command echo) and the board TX pin.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- BIT_CYCLES, CLK_FREQ/BAUD (integer divide, 10416 at defaults), clock cycles per bit. Derived localparam, not overridden directly.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- req, input, NUM_REQ, per-requester level request. Held high until granted.
- req_data, input, 8*NUM_REQ, byte for requester i in bits [8i+7:8i]. Stable while req[i] is high.
- grant, output, NUM_REQ, one-hot single-cycle pulse. The byte of that requester is captured this cycle.
- active_id, output, $clog2(NUM_REQ), index of the requester currently being transmitted.
- busy, output, 1, high from the grant cycle through the last stop-bit cycle.
- tx, output, 1, registered serial output; idle high.

Behaviour:
- Reset (asynchronous, active-high):
  - tx=1, grant=0, busy=0, active_id=0.
  - State=IDLE, round-robin pointer=0, tick counter=0, bit index=0.
  - Reset mid-frame aborts the frame immediately. tx returns high with no stop bit. The interrupted requester is not re-granted automatically.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - If any req bit is high, select the first asserted index searching from pointer upward with wrap-around (pointer, pointer+1, ... NUM_REQ-1, 0, ...).
  - In the same cycle: pulse grant[sel], latch req_data slice into the shift register, set active_id=sel, busy=1, pointer=(sel+1) mod NUM_REQ, clear the tick counter, go to START.
  - If no req bit is high, stay in IDLE with tx=1.
- START: tx=0 from the cycle after grant for exactly BIT_CYCLES cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift register bit[index] for BIT_CYCLES cycles each, index 0..7 (LSB first).
  - After index 7 completes, go to STOP.
- STOP: tx=1 for BIT_CYCLES cycles. On the final cycle, set busy=0 and go to IDLE.
- Frame timing:
  - tx is low for the start bit exactly 1 cycle after the grant pulse.
  - A full frame is 10*BIT_CYCLES cycles.
  - Back-to-back frames are separated by exactly 1 IDLE cycle: the tx-high stop period plus 1 extra cycle before the next start bit.
- Tick counter:
  - 0..BIT_CYCLES-1; the tick fires when the count equals BIT_CYCLES-1, then the counter wraps to 0.
  - Cleared on grant so every bit has exactly BIT_CYCLES cycles.
  - Counter width is $clog2(BIT_CYCLES).
- Requests while busy are ignored. No grant is issued until IDLE. Requests are not queued internally.
- Requester dropping req before grant: it is simply not selected. A request dropped on the same cycle it would be granted is not granted, because selection uses the current-cycle req.
- grant is never asserted for more than one requester or for more than one cycle per frame.
- active_id holds its value after the frame ends until the next grant.

Decomposition:
- Shared package uart_pkg:
  - state enum: IDLE, START, DATA, STOP.
  - DATA_BITS=8 and STOP_BITS=1 constants.
  - Default CLK_FREQ and BAUD constants, shared with the existing baud generator.
- One sub-module, uart_baud_tick:
  - Parameter BIT_CYCLES; inputs clk, rst, clear; output tick (1-cycle pulse).
  - The scheduler instantiates it and holds clear high in IDLE.
- Round-robin selection stays inline as a function in the scheduler.

Test Plan:
All scenarios use CLK_FREQ=1000 and BAUD=100, so BIT_CYCLES=10.
- Single byte: req[0]=1, req_data[7:0]=8'hA5 →
  - grant=4'b0001 for 1 cycle; tx low 1 cycle later for 10 cycles.
  - Then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high for 10 cycles.
  - busy low after 100 cycles from grant.
- Round-robin: req=4'b1111 held, bytes 8'h11/22/33/44 →
  - Grants in order 0,1,2,3,0.
  - Consecutive grant pulses exactly 101 cycles apart.
- Pointer wrap: first grant to requester 3, then req=4'b1001 → next grant goes to requester 0, not 3.
- Request during busy: req[2] rises mid-frame of requester 1 → no grant until IDLE; grant[2] 1 cycle after the frame ends.
- Mid-frame reset: assert rst during DATA bit 4 →
  - tx=1, busy=0, grant=0 asynchronously.
  - After release with req[1] high: grant[1] on the first clock edge, with a full 10-cycle start bit.
- Withdrawn request: req[2] pulses high for 1 cycle while busy, low at IDLE → no grant issued; tx stays high.
